ecc_err_telemetry: RTL and testbench

Downstream consumer of the ECC engine's registered telemetry (syndrome, SBE flag, DBE flag). Aggregates errors into per-window SBE/DBE counts, raises storm and repeated-syndrome alerts, and queues one timestamped event record per error into a small FIFO drained by the ML engine over a valid/ready interface. Purely observational; never touches the data path.

---
 rtl/ecc_err_telemetry.sv | 178 +++++++++++++++++
 tb/tb_ecc_err_telemetry.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_err_telemetry.sv
// ecc_err_telemetry
//   Observes the ECC engine's registered telemetry (syndrome, SBE, DBE).
//   It keeps per-window SBE/DBE counts and raises sticky storm and
//   repeated-syndrome alerts. Each error is queued as a record in a small
//   first-word-fall-through FIFO that the ML engine drains.
//   This block never touches the data path.
//
//   Optional build macro: ECC_TELEM_TS_EN
//     defined   -> a free-running 16-bit timestamp fills evt_data[15:0]
//     undefined -> the timestamp counter is absent and evt_data[15:0] = 0
//
//   Handshake: evt_valid is high while the FIFO holds at least one record.
//   A record transfers on any rising clk edge with evt_valid && evt_ready.
//   evt_data holds steady while evt_valid && !evt_ready.
//   A record is accepted when the FIFO is not full. It is also accepted when
//   the FIFO is full but the head pops in the same cycle. Otherwise it is
//   dropped and evt_overflow is set.
module ecc_err_telemetry #(
   parameter int ECC_WIDTH     = 8,
   parameter int CNT_WIDTH     = 16,
   parameter int WINDOW_CYCLES = 1024,
   parameter int SBE_THRESH    = 4,
   parameter int REPEAT_THRESH = 3,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ECC_WIDTH-1:0]      tel_syndrome,
   input  logic                      tel_sbe,
   input  logic                      tel_dbe,
   input  logic                      clr_sticky,
   output logic                      evt_valid,
   input  logic                      evt_ready,
   output logic [2+ECC_WIDTH+16-1:0] evt_data,
   output logic [CNT_WIDTH-1:0]      win_sbe_cnt,
   output logic [CNT_WIDTH-1:0]      win_dbe_cnt,
   output logic                      win_done,
   output logic                      storm_alert,
   output logic                      repeat_alert,
   output logic                      evt_overflow
);

   localparam int REC_W = 2 + ECC_WIDTH + 16;
   localparam int WP_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int RC_W  = $clog2(REPEAT_THRESH + 1);

   localparam logic [WP_W-1:0]      WP_LAST = WP_W'(WINDOW_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] SBE_TH  = CNT_WIDTH'(SBE_THRESH);
   localparam logic [RC_W-1:0]      REP_TH  = RC_W'(REPEAT_THRESH);

   // A DBE takes priority when both flags are set in the same beat.
   logic w_is_dbe, w_is_sbe, w_is_evt, w_win_last;
   assign w_is_dbe   = tel_dbe;
   assign w_is_sbe   = tel_sbe & ~tel_dbe;
   assign w_is_evt   = tel_sbe | tel_dbe;

   logic [WP_W-1:0] r_win_pos;
   assign w_win_last = (r_win_pos == WP_LAST);

   // ---------------- timestamp ----------------
   logic [15:0] w_ts;
`ifdef ECC_TELEM_TS_EN
   logic [15:0] r_ts;
   // Free-running timestamp; it wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ts <= '0;
      else        r_ts <= r_ts + 16'd1;
   end
   assign w_ts = r_ts;
`else
   assign w_ts = '0;
`endif

   // ---------------- window counters ----------------
   logic [CNT_WIDTH-1:0] r_cur_sbe, r_cur_dbe, w_sbe_next, w_dbe_next;
   always_comb begin
      w_sbe_next = r_cur_sbe;
      w_dbe_next = r_cur_dbe;
      if (w_is_sbe && r_cur_sbe != CNT_MAX) w_sbe_next = r_cur_sbe + CNT_WIDTH'(1);
      if (w_is_dbe && r_cur_dbe != CNT_MAX) w_dbe_next = r_cur_dbe + CNT_WIDTH'(1);
   end

   // Window position and counts. An event on the closing cycle still counts into that window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win_pos   <= '0;
         r_cur_sbe   <= '0;
         r_cur_dbe   <= '0;
         win_sbe_cnt <= '0;
         win_dbe_cnt <= '0;
         win_done    <= 1'b0;
      end else begin
         win_done <= w_win_last;
         if (w_win_last) begin
            r_win_pos   <= '0;
            win_sbe_cnt <= w_sbe_next;
            win_dbe_cnt <= w_dbe_next;
            r_cur_sbe   <= '0;
            r_cur_dbe   <= '0;
         end else begin
            r_win_pos <= r_win_pos + WP_W'(1);
            r_cur_sbe <= w_sbe_next;
            r_cur_dbe <= w_dbe_next;
         end
      end
   end

   // ---------------- repeat tracker ----------------
   logic [ECC_WIDTH-1:0] r_last_syn, w_last_syn_next;
   logic [RC_W-1:0]      r_rep_cnt, w_rep_next;
   always_comb begin
      w_last_syn_next = r_last_syn;
      w_rep_next      = r_rep_cnt;
      if (w_is_dbe) begin
         w_rep_next = '0;
      end else if (w_is_sbe) begin
         if (tel_syndrome == r_last_syn) begin
            if (r_rep_cnt != REP_TH) w_rep_next = r_rep_cnt + RC_W'(1);
         end else begin
            w_last_syn_next = tel_syndrome;
            w_rep_next      = RC_W'(1);
         end
      end
   end

   // Tracker state and sticky alerts. A set in the same cycle as clr_sticky wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_syn   <= '0;
         r_rep_cnt    <= '0;
         storm_alert  <= 1'b0;
         repeat_alert <= 1'b0;
      end else begin
         r_last_syn <= w_last_syn_next;
         r_rep_cnt  <= w_rep_next;
         if (w_is_sbe && w_sbe_next >= SBE_TH) storm_alert <= 1'b1;
         else if (clr_sticky)                  storm_alert <= 1'b0;
         if (w_is_sbe && w_rep_next == REP_TH) repeat_alert <= 1'b1;
         else if (clr_sticky)                  repeat_alert <= 1'b0;
      end
   end

   // ---------------- event FIFO ----------------
   logic [REC_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW:0]      r_wr_ptr, r_rd_ptr;
   logic             w_full, w_empty, w_pop, w_push;
   logic [REC_W-1:0] w_rec;

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop     = ~w_empty & evt_ready;
   assign w_push    = w_is_evt & (~w_full | w_pop);
   assign w_rec     = {(w_is_dbe ? 2'b10 : 2'b01), tel_syndrome, w_ts};
   assign evt_valid = ~w_empty;
   assign evt_data  = r_mem[r_rd_ptr[AW-1:0]];

   // FIFO storage, pointers and the sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         evt_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_rec;
            r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         if (w_is_evt && !w_push) evt_overflow <= 1'b1;
         else if (clr_sticky)     evt_overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ecc_err_telemetry.sv
// tb_ecc_err_telemetry
//   Bench for ecc_err_telemetry with WINDOW_CYCLES=16 and default thresholds.
//   It checks the reset state, window aggregation, the storm and repeat
//   alerts, FIFO ordering and overflow, and reset in mid-operation.
//   Event records are checked against an expected queue as they pop.
module tb_ecc_err_telemetry;

   localparam int W = 26;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   tel_syndrome = '0;
   logic         tel_sbe = 1'b0, tel_dbe = 1'b0, clr_sticky = 1'b0, evt_ready = 1'b0;
   logic         evt_valid;
   logic [W-1:0] evt_data;
   logic [15:0]  win_sbe_cnt, win_dbe_cnt;
   logic         win_done, storm_alert, repeat_alert, evt_overflow;

   int n_checks = 0;
   int n_err    = 0;
   int m_ts     = 0;   // cycles since reset release, i.e. timestamp and window position
   int m_occ    = 0;   // modelled FIFO occupancy
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic       sbe;
      logic       dbe;
      logic [7:0] syn;
      logic       clr;
      logic       exp_rep;
   } rep_vec_t;
   rep_vec_t tbl[13];

   ecc_err_telemetry #(.WINDOW_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .tel_syndrome(tel_syndrome), .tel_sbe(tel_sbe),
      .tel_dbe(tel_dbe), .clr_sticky(clr_sticky), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .evt_data(evt_data), .win_sbe_cnt(win_sbe_cnt),
      .win_dbe_cnt(win_dbe_cnt), .win_done(win_done), .storm_alert(storm_alert),
      .repeat_alert(repeat_alert), .evt_overflow(evt_overflow)
   );

   // clock / watchdog
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] ts_exp(input int t);
`ifdef ECC_TELEM_TS_EN
      return 16'(t);
`else
      return 16'h0000;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs at negedge, score the head pop, then return 1 ns after posedge.
   task automatic step(input logic sbe, input logic dbe, input logic [7:0] syn,
                       input logic rdy, input logic clr);
      logic         pop_m;
      logic [W-1:0] rec;
      @(negedge clk);
      tel_sbe      = sbe;
      tel_dbe      = dbe;
      tel_syndrome = (sbe | dbe) ? syn : 8'($urandom_range(0, 255));
      evt_ready    = rdy;
      clr_sticky   = clr;
      chk("evt_valid_vs_model", {31'd0, evt_valid}, {31'd0, m_occ != 0});
      if (evt_valid && evt_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL sb_pop: got record 0x%0h expected none", evt_data);
         end else begin
            rec = exp_q.pop_front();
            chk("sb_evt_data", {6'd0, evt_data}, {6'd0, rec});
         end
      end
      pop_m = (m_occ != 0) && rdy;
      if (sbe | dbe) begin
         rec = {(dbe ? 2'b10 : 2'b01), syn, ts_exp(m_ts)};
         if (m_occ < 8 || pop_m) begin
            exp_q.push_back(rec);
            m_occ++;
         end
      end
      if (pop_m) m_occ--;
      @(posedge clk);
      #1;
      m_ts++;
   endtask

   task automatic idle_to(input int p);
      while ((m_ts % 16) != p) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 8'h13, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 8'h13, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 8'h0B, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 8'h13, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 8'h13, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 8'h13, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 1'b1, 8'h2A, 1'b1, 1'b0};  // SBE+DBE = DBE; clr clears repeat
      tbl[7]  = '{1'b1, 1'b0, 8'h13, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 8'h13, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b0};  // DBE breaks the run
      tbl[10] = '{1'b1, 1'b0, 8'h13, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 8'h13, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 8'h13, 1'b0, 1'b1};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
      chk("rst_evt_data", {6'd0, evt_data}, 32'd0);
      chk("rst_win_sbe", {16'd0, win_sbe_cnt}, 32'd0);
      chk("rst_win_dbe", {16'd0, win_dbe_cnt}, 32'd0);
      chk("rst_win_done", {31'd0, win_done}, 32'd0);
      chk("rst_storm", {31'd0, storm_alert}, 32'd0);
      chk("rst_repeat", {31'd0, repeat_alert}, 32'd0);
      chk("rst_overflow", {31'd0, evt_overflow}, 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // first record at ts=5, visible the next cycle
      repeat (5) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'h07, 1'b1, 1'b0);
      chk("first_valid", {31'd0, evt_valid}, 32'd1);
      chk("first_data", {6'd0, evt_data}, {6'd0, 2'b01, 8'h07, ts_exp(5)});
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("first_popped", {31'd0, evt_valid}, 32'd0);

      // window: 3 SBE + 1 DBE, the last SBE on the closing cycle
      idle_to(0);
      for (int p = 0; p < 16; p++) begin
         if (p == 15) chk("win_done_pre", {31'd0, win_done}, 32'd0);
         case (p)
            2:       step(1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
            5:       step(1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
            9:       step(1'b1, 1'b0, 8'h04, 1'b1, 1'b0);
            15:      step(1'b1, 1'b0, 8'h08, 1'b1, 1'b0);
            default: step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
         endcase
      end
      chk("win_done_pulse", {31'd0, win_done}, 32'd1);
      chk("win_sbe_3", {16'd0, win_sbe_cnt}, 32'd3);
      chk("win_dbe_1", {16'd0, win_dbe_cnt}, 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("win_done_fall", {31'd0, win_done}, 32'd0);
      idle_to(0);
      chk("win_restart_sbe", {16'd0, win_sbe_cnt}, 32'd0);
      chk("win_restart_dbe", {16'd0, win_dbe_cnt}, 32'd0);

      // storm alert
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'h10, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'h20, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'h30, 1'b1, 1'b0);
      chk("storm_below", {31'd0, storm_alert}, 32'd0);
      step(1'b1, 1'b0, 8'h40, 1'b1, 1'b0);
      chk("storm_set", {31'd0, storm_alert}, 32'd1);
      idle_to(0);
      chk("storm_hold_rollover", {31'd0, storm_alert}, 32'd1);
      chk("storm_win_sbe", {16'd0, win_sbe_cnt}, 32'd4);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      chk("storm_clr", {31'd0, storm_alert}, 32'd0);
      step(1'b1, 1'b0, 8'h11, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'h21, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'h31, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'h41, 1'b1, 1'b1);
      chk("storm_set_wins", {31'd0, storm_alert}, 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      chk("storm_clr2", {31'd0, storm_alert}, 32'd0);

      // repeat tracker, table driven, one window
      idle_to(0);
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].sbe, tbl[i].dbe, tbl[i].syn, 1'b1, tbl[i].clr);
         chk($sformatf("repeat_vec%0d", i), {31'd0, repeat_alert}, {31'd0, tbl[i].exp_rep});
      end
      idle_to(0);
      chk("rep_win_sbe", {16'd0, win_sbe_cnt}, 32'd11);
      chk("rep_win_dbe", {16'd0, win_dbe_cnt}, 32'd2);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      chk("rep_clr", {31'd0, repeat_alert}, 32'd0);

      // overflow with evt_ready low
      for (int i = 0; i < 9; i++) begin
         step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
         if (i == 7) chk("ovf_not_yet", {31'd0, evt_overflow}, 32'd0);
      end
      chk("ovf_set", {31'd0, evt_overflow}, 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovf_clr", {31'd0, evt_overflow}, 32'd0);
      step(1'b1, 1'b0, 8'h70, 1'b1, 1'b0);
      chk("full_push_pop", {31'd0, evt_overflow}, 32'd0);
      for (int i = 0; i < 64 && m_occ != 0; i++)
         step(1'b0, 1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
      chk("drain_done", 32'(m_occ), 32'd0);
      chk("drain_valid", {31'd0, evt_valid}, 32'd0);
      chk("drain_queue", 32'(exp_q.size()), 32'd0);

      // reset in mid-operation
      step(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h3D, 1'b0, 1'b0);
      chk("pre_rst_valid", {31'd0, evt_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, evt_valid}, 32'd0);
      chk("midrst_data", {6'd0, evt_data}, 32'd0);
      chk("midrst_storm", {31'd0, storm_alert}, 32'd0);
      chk("midrst_win_sbe", {16'd0, win_sbe_cnt}, 32'd0);
      exp_q.delete();
      m_occ = 0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      m_ts  = 0;
      step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
      chk("post_rst_data", {6'd0, evt_data}, {6'd0, 2'b10, 8'h55, ts_exp(0)});
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("post_rst_drained", {31'd0, evt_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
